// File: rtl/tick_scheduler.sv
// Tick scheduler: four clkdiv-bit edge detectors producing one-cycle enable
// strobes, gated by a small run/pause/single-step FSM, with a game-step counter.
module tick_scheduler #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned RST_SEL0 = 18,
    parameter int unsigned RST_SEL1 = 20,
    parameter int unsigned RST_SEL2 = 22,
    parameter int unsigned RST_SEL3 = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clkdiv,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_ch,
    input  logic [4:0]       cfg_bit,
    output logic [3:0]       tick,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2,
        StStep   = 2'd3
    } state_e;

    localparam logic [3:0][4:0] RstSel = {5'(RST_SEL3), 5'(RST_SEL2),
                                          5'(RST_SEL1), 5'(RST_SEL0)};

    state_e           state_q, state_d;
    logic [3:0][4:0]  sel_q, sel_d;
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       tick_q, tick_d;
    logic [3:0]       cur, edge_raw, en;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Sample each channel's selected divider bit and detect its rising edge
    always_comb begin
        cur = '0;
        for (int i = 0; i < 4; i++) begin
            cur[i] = clkdiv[sel_q[i]];
        end
        edge_raw = cur & ~prev_q;
    end

    // Channel reconfiguration and gated tick generation; a write masks that channel's edge
    always_comb begin
        sel_d  = sel_q;
        prev_d = cur;
        tick_d = edge_raw & en;
        if (cfg_we) begin
            sel_d[cfg_ch]  = cfg_bit;
            prev_d[cfg_ch] = clkdiv[cfg_bit];
            tick_d[cfg_ch] = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; higher-priority commands mask lower ones in every state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!stop && !pause && start) state_d = StRun;
            end
            StRun: begin
                if (stop)       state_d = StIdle;
                else if (pause) state_d = StPaused;
            end
            StPaused: begin
                if (stop)       state_d = StIdle;
                else if (pause) state_d = StPaused;
                else if (start) state_d = StRun;
                else if (step)  state_d = StStep;
            end
            StStep: begin
                if (stop)             state_d = StIdle;
                else if (pause)       state_d = StPaused;
                else if (edge_raw[1]) state_d = StPaused;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: channel enables (an aborted step gets no game ticks) and step counter
    always_comb begin
        en = 4'b0001;
        case (state_q)
            StRun:   en = 4'b1111;
            StStep:  if (!stop && !pause) en = 4'b1111;
            default: en = 4'b0001;
        endcase
        cnt_d = cnt_q;
        if (state_q == StIdle && start && !stop && !pause) begin
            cnt_d = '0;
        end else if (tick_q[1]) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel and counter registers; prev resets high to mask a first-cycle edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q  <= RstSel;
            prev_q <= '1;
            tick_q <= '0;
            cnt_q  <= '0;
        end else begin
            sel_q  <= sel_d;
            prev_q <= prev_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tick     = tick_q;
    assign state    = state_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus random commands, each cycle
// compared against a behavioural model built from the command/edge rules.
module tb_tick_scheduler;

    localparam int CNT_W = 8;
    localparam int RS0 = 6;
    localparam int RS1 = 8;
    localparam int RS2 = 9;
    localparam int RS3 = 10;
    localparam int IDLE = 0, RUN = 1, PAUSED = 2, STEPS = 3;
    localparam int C_NONE = 0, C_STOP = 1, C_PAUSE = 2, C_START = 3, C_STEP = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      clkdiv;
    logic             start, pause, step, stop, cfg_we;
    logic [1:0]       cfg_ch;
    logic [4:0]       cfg_bit;
    logic [3:0]       tick;
    logic [1:0]       state;
    logic [CNT_W-1:0] step_cnt;

    int checks = 0;
    int errors = 0;

    // reference model
    int   m_state;
    int   m_cnt;
    int   m_sel[4];
    bit   m_prev[4];
    bit [3:0] m_tick;

    tick_scheduler #(
        .CNT_W(CNT_W), .RST_SEL0(RS0), .RST_SEL1(RS1), .RST_SEL2(RS2), .RST_SEL3(RS3)
    ) dut (
        .clk(clk), .rst(rst), .clkdiv(clkdiv), .start(start), .pause(pause), .step(step),
        .stop(stop), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_bit(cfg_bit), .tick(tick),
        .state(state), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int win;
        bit e[4];
        bit [3:0] nt;
        if (!rst) begin
            m_state = IDLE;
            m_cnt   = 0;
            m_tick  = '0;
            m_sel   = '{RS0, RS1, RS2, RS3};
            m_prev  = '{1, 1, 1, 1};
            return;
        end
        win = stop ? C_STOP : pause ? C_PAUSE : start ? C_START : step ? C_STEP : C_NONE;
        for (int i = 0; i < 4; i++) begin
            bit cur;
            bit allowed;
            cur = clkdiv[m_sel[i]];
            e[i] = cur && !m_prev[i];
            allowed = (i == 0) || (m_state == RUN) ||
                      (m_state == STEPS && win != C_STOP && win != C_PAUSE);
            nt[i] = e[i] && allowed && !(cfg_we && int'(cfg_ch) == i);
            m_prev[i] = cur;
        end
        if (cfg_we) begin
            m_sel[cfg_ch]  = int'(cfg_bit);
            m_prev[cfg_ch] = clkdiv[cfg_bit];
        end
        if (m_state == IDLE && win == C_START) m_cnt = 0;
        else if (m_tick[1]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        case (m_state)
            IDLE:   if (win == C_START) m_state = RUN;
            RUN:    if (win == C_STOP) m_state = IDLE; else if (win == C_PAUSE) m_state = PAUSED;
            PAUSED: if (win == C_STOP) m_state = IDLE;
                    else if (win == C_START) m_state = RUN;
                    else if (win == C_STEP) m_state = STEPS;
            default: if (win == C_STOP) m_state = IDLE;
                     else if (win == C_PAUSE || e[1]) m_state = PAUSED;
        endcase
        m_tick = nt;
    endtask

    // One clock: model update, edge, settle, then free-running divider advances
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        clkdiv = clkdiv + 32'd1;
    endtask

    task automatic idle_inputs();
        start = 0; pause = 0; step = 0; stop = 0; cfg_we = 0; cfg_ch = 0; cfg_bit = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        clkdiv = 32'h1234_5678;
        cycle();
        checks++;
        if (tick !== 4'd0 || state !== 2'd0 || step_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: tick=%b state=%0d cnt=%0d want 0/0/0", tick, state, step_cnt);
        end
        cycle();
        rst = 1;
        clkdiv = 0;
        cycle();
        checks++;
        if (tick !== 4'd0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: tick=%b state=%0d want 0/0", tick, state);
        end
    endtask

    task automatic test_idle_display();
        int n0 = 0;
        for (int c = 0; c < 300; c++) begin
            cycle();
            n0 += int'(tick[0]);
            checks++;
            if (tick !== m_tick || state !== 2'(m_state) || step_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL idle_cycle%0d: tick=%b st=%0d cnt=%0d want %b/%0d/%0d",
                         c, tick, state, step_cnt, m_tick, m_state, m_cnt);
            end
        end
        // clkdiv ran 1..301 here: bit 6 rises at 64 and 192
        checks++;
        if (n0 != 2) begin
            errors++;
            $display("FAIL idle_tick0_count: got %0d want 2", n0);
        end
    endtask

    task automatic test_run();
        int n1 = 0;
        int c0;
        cfg_we = 1; cfg_ch = 1; cfg_bit = 2;
        cycle();
        idle_inputs();
        start = 1;
        cycle();
        start = 0;
        checks++;
        if (state !== 2'd1 || step_cnt !== '0) begin
            errors++;
            $display("FAIL run_enter: state=%0d cnt=%0d want 1/0", state, step_cnt);
        end
        c0 = int'(step_cnt);
        for (int c = 0; c < 64; c++) begin
            cycle();
            n1 += int'(tick[1]);
            checks++;
            if (tick !== m_tick || state !== 2'(m_state) || step_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL run_cycle%0d: tick=%b st=%0d cnt=%0d want %b/%0d/%0d",
                         c, tick, state, step_cnt, m_tick, m_state, m_cnt);
            end
        end
        checks++;
        if (n1 != 8) begin
            errors++;
            $display("FAIL run_tick1_count: got %0d want 8", n1);
        end
        checks++;
        if (int'(step_cnt) < c0 + 7 || int'(step_cnt) > c0 + 8) begin
            errors++;
            $display("FAIL run_cnt_advance: got %0d want %0d..%0d", step_cnt, c0 + 7, c0 + 8);
        end
    endtask

    task automatic test_pause_resume();
        int n1 = 0;
        int n0 = 0;
        logic [CNT_W-1:0] held;
        pause = 1;
        cycle();
        pause = 0;
        n1 += int'(tick[1]);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL pause_state: state=%0d want 2", state);
        end
        for (int c = 0; c < 200; c++) begin
            cycle();
            n1 += int'(tick[1]);
            n0 += int'(tick[0]);
            checks++;
            if (tick !== m_tick || state !== 2'(m_state) || step_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL pause_cycle%0d: tick=%b st=%0d cnt=%0d want %b/%0d/%0d",
                         c, tick, state, step_cnt, m_tick, m_state, m_cnt);
            end
        end
        checks++;
        if (n1 > 1 || n0 == 0) begin
            errors++;
            $display("FAIL pause_ticks: tick1=%0d want <=1, tick0=%0d want >0", n1, n0);
        end
        held = step_cnt;
        start = 1;
        cycle();
        start = 0;
        checks++;
        if (state !== 2'd1 || step_cnt !== held) begin
            errors++;
            $display("FAIL resume: state=%0d cnt=%0d want 1/%0d", state, step_cnt, held);
        end
        for (int c = 0; c < 16; c++) begin
            cycle();
            checks++;
            if (tick !== m_tick || state !== 2'(m_state) || step_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL resume_cycle%0d: tick=%b st=%0d cnt=%0d want %b/%0d/%0d",
                         c, tick, state, step_cnt, m_tick, m_state, m_cnt);
            end
        end
    endtask

    task automatic test_step();
        int n1 = 0;
        int seen_step = 0;
        logic [CNT_W-1:0] held;
        pause = 1;
        cycle();
        idle_inputs();
        cfg_we = 1; cfg_ch = 1; cfg_bit = 3;
        cycle();
        idle_inputs();
        cycle();
        held = step_cnt;
        step = 1;
        cycle();
        step = 0;
        for (int c = 0; c < 20; c++) begin
            seen_step += (state == 2'd3) ? 1 : 0;
            cycle();
            n1 += int'(tick[1]);
            checks++;
            if (tick !== m_tick || state !== 2'(m_state) || step_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL step_cycle%0d: tick=%b st=%0d cnt=%0d want %b/%0d/%0d",
                         c, tick, state, step_cnt, m_tick, m_state, m_cnt);
            end
        end
        checks++;
        if (n1 != 1 || seen_step == 0 || state !== 2'd2 || step_cnt !== held + CNT_W'(1)) begin
            errors++;
            $display("FAIL step_single: ticks=%0d stepcycles=%0d state=%0d cnt=%0d want 1/>0/2/%0d",
                     n1, seen_step, state, step_cnt, held + CNT_W'(1));
        end
    endtask

    task automatic test_cfg_and_stop();
        cfg_we = 1; cfg_ch = 2; cfg_bit = 2;
        cycle();
        idle_inputs();
        start = 1;
        cycle();
        start = 0;
        // reach a cycle where bit 2 has just gone high, i.e. a live ch2 edge
        for (int c = 0; c < 8 && clkdiv[2:0] != 3'd4; c++) cycle();
        cfg_we = 1; cfg_ch = 2; cfg_bit = 2;
        cycle();
        cfg_we = 0;
        checks++;
        if (tick[2] !== 1'b0 || tick !== m_tick) begin
            errors++;
            $display("FAIL cfg_masks_edge: tick=%b want %b with tick[2]=0", tick, m_tick);
        end
        start = 1; stop = 1;
        cycle();
        idle_inputs();
        checks++;
        if (state !== 2'd0 || state !== 2'(m_state)) begin
            errors++;
            $display("FAIL start_stop_run: state=%0d want 0", state);
        end
    endtask

    task automatic test_wrap();
        int wraps = 0;
        logic [CNT_W-1:0] last;
        cfg_we = 1; cfg_ch = 1; cfg_bit = 0;
        cycle();
        idle_inputs();
        start = 1;
        cycle();
        start = 0;
        last = step_cnt;
        for (int c = 0; c < 540; c++) begin
            cycle();
            if (last == '1 && step_cnt == '0) wraps++;
            last = step_cnt;
            checks++;
            if (tick !== m_tick || state !== 2'(m_state) || step_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL wrap_cycle%0d: tick=%b st=%0d cnt=%0d want %b/%0d/%0d",
                         c, tick, state, step_cnt, m_tick, m_state, m_cnt);
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL wrap_seen: wraps=%0d want 1", wraps);
        end
    endtask

    task automatic test_reset_mid_step();
        pause = 1;
        cycle();
        idle_inputs();
        cfg_we = 1; cfg_ch = 1; cfg_bit = 9;
        cycle();
        idle_inputs();
        step = 1;
        cycle();
        step = 0;
        cycle();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL step_pending: state=%0d want 3", state);
        end
        rst = 0;
        cycle();
        rst = 1;
        checks++;
        if (state !== 2'd0 || tick !== 4'd0 || step_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid_step: tick=%b st=%0d cnt=%0d want 0/0/0", tick, state, step_cnt);
        end
        cycle();
        checks++;
        if (tick !== 4'd0 || tick !== m_tick) begin
            errors++;
            $display("FAIL reset_after: tick=%b want 0", tick);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            rst    = ($urandom_range(199) != 0);
            stop   = ($urandom_range(15) == 0);
            pause  = ($urandom_range(11) == 0);
            start  = ($urandom_range(7) == 0);
            step   = ($urandom_range(5) == 0);
            cfg_we = ($urandom_range(9) == 0);
            cfg_ch = 2'($urandom_range(3));
            cfg_bit = 5'($urandom_range(6));
            if ($urandom_range(49) == 0) clkdiv = $urandom;
            cycle();
            checks++;
            if (tick !== m_tick || state !== 2'(m_state) || step_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL random_cycle%0d: tick=%b st=%0d cnt=%0d want %b/%0d/%0d",
                         c, tick, state, step_cnt, m_tick, m_state, m_cnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        clkdiv = 0;
        idle_inputs();
        #1;
        test_reset();
        test_idle_display();
        test_run();
        test_pause_resume();
        test_step();
        test_cfg_and_stop();
        test_wrap();
        test_reset_mid_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
